activation_pwl_array: RTL and testbench
=======================================

# activation_pwl_array

Parametrised, fully pipelined activation stage sitting between the systolic array output and the pooling/writeback path. It accepts one row of LANES skewed results per cycle, with lane i arriving i cycles after lane 0. Each lane applies one of bypass, ReLU, leaky ReLU or an odd-symmetric piecewise-linear tanh with uniform two-cycle latency. It honours a per-lane validity mask and raises a sticky done flag after a programmable number of rows.

## Interface
- DWIDTH, 8, signed two's-complement element width (>= 8).
- LANES, 8, number of lanes / array columns.
- ROWS_PER_DONE, 4, rows counted before done_activation asserts (>= 1).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- enable_activation  in  1  0 = bypass (data passes through pipeline unchanged).
- activation_type  in  2  00 ReLU, 01 PWL tanh, 10 leaky ReLU, 11 bypass.
- leak_shift  in  3  arithmetic right-shift for leaky ReLU negatives.
- in_data_available  in  1  lane-0 valid for the current row.
- inp_data  in  LANES*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH].
- validity_mask  in  LANES  per-lane enable; 0 forces lane output to 0.
- done_clear  in  1  clears done_activation and the row counter.
- out_data  out  LANES*DWIDTH  registered per-lane results.
- out_lane_valid  out  LANES  per-lane output valid.
- out_data_available  out  1  equals out_lane_valid[LANES-1] (row complete).
- done_activation  out  1  sticky row-count-reached flag.

## Operation
- Skew: lane i valid is in_data_available delayed by i cycles through an internal shift chain. inp_data lane i, validity_mask[i], activation_type, enable_activation and leak_shift are sampled when lane i valid is high.
- Per-lane pipeline:
  - S1 registers the operand, the control bits and, for tanh, m = |x| (most-negative value maps to F-1, F = 2^(DWIDTH-1)) plus the sign.
  - S2 computes the result and registers it into out_data.
- Effective mode is bypass if enable_activation = 0 or activation_type = 11.
- ReLU: y = (x < 0) ? 0 : x.
- Leaky: y = (x < 0) ? x >>> leak_shift : x.
- PWL tanh magnitude segments:
  - m < F/4: p = 2m.
  - m < F/2: p = m + F/4.
  - m < 3F/4: p = (m>>1) + F/2.
  - otherwise: p = min(F-1, (m>>2) + 11F/16).
  - y = sign ? -p : p.
  - For DWIDTH = 8 the breakpoints are 32/64/96 and the final offset is 88.
- Mask: a sampled mask bit of 0 drives that lane's result to 0. out_lane_valid still asserts.
- out_data lanes hold their last value until the next valid result for that lane.
- Row counter:
  - Counter of width clog2(ROWS_PER_DONE+1) increments on each out_data_available cycle.
  - When the count reaches ROWS_PER_DONE, done_activation sets and stays set.
  - The counter saturates.
  - done_clear (or reset) zeroes both. If done_clear and out_data_available coincide, the clear wins and the row is not counted.

## Timing
- Reset: out_data = 0, out_lane_valid = 0, out_data_available = 0, done_activation = 0. The skew chain, pipeline valids and counter clear. Reset mid-row discards all in-flight data; no valid asserts until new input after reset deasserts.
- Latency:
  - in_data_available high at edge t: lane i data must be presented at edge t+i.
  - out_lane_valid[i] is high for the cycle following edge t+i+2.
  - out_data_available is high in the cycle after edge t+LANES+1.
- Throughput is one row per cycle; back-to-back in_data_available is legal and produces back-to-back valids.
- Mode/mask changes take effect per lane, on the row whose lane sample coincides with the change. There is no pipeline flush.
- done_activation rises in the cycle after the edge where the ROWS_PER_DONE-th out_data_available is registered.

## Test plan
- Bypass, DWIDTH=8, LANES=8: rows with lane i = i-4, with enable_activation = 0 -> out lane i = i-4 at t+i+2; out_data_available at t+9.
- ReLU, 8-bit, full mask:
  - Lanes {-128,-1,0,1,5,-7,127,-50} -> {0,0,0,1,5,0,127,0}.
  - Then mask 8'b1111_0000 -> lanes 0-3 = 0 and valids still asserted.
- Leaky, leak_shift = 2: inputs {-128,-5,-1,12} -> {-32,-2,-1,12}.
- PWL tanh, 8-bit: inputs {0,10,31,32,50,64,80,96,127,-128,-40} -> {0,20,62,64,82,96,104,112,119,-119,-72}.
- Streaming and done, ROWS_PER_DONE = 4:
  - 6 back-to-back rows -> 6 consecutive out_data_available cycles; done rises after the 4th.
  - done_clear asserted in the same cycle as row 5's out_data_available -> counter = 0, done = 0.
  - Row 6's out_data_available then counts -> counter = 1.
- Reset mid-stream: reset asserted at t+3 of a row -> all valids 0 next cycle, outputs 0; no stale valid afterwards. A new row after reset completes with nominal latency.

Source files
------------

// File: rtl/activation_pwl_array.sv
// rtl/activation_pwl_array.sv - skewed per-lane activation stage (bypass/ReLU/leaky/PWL tanh) with row counter
module activation_pwl_array #(
    parameter int DWIDTH        = 8,
    parameter int LANES         = 8,
    parameter int ROWS_PER_DONE = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_activation,
    input  logic [1:0]                activation_type,
    input  logic [2:0]                leak_shift,
    input  logic                      in_data_available,
    input  logic [LANES*DWIDTH-1:0]   inp_data,
    input  logic [LANES-1:0]          validity_mask,
    input  logic                      done_clear,
    output logic [LANES*DWIDTH-1:0]   out_data,
    output logic [LANES-1:0]          out_lane_valid,
    output logic                      out_data_available,
    output logic                      done_activation
);

    localparam int CW = $clog2(ROWS_PER_DONE + 1);

    localparam logic [1:0] MODE_RELU   = 2'b00;
    localparam logic [1:0] MODE_TANH   = 2'b01;
    localparam logic [1:0] MODE_LEAKY  = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    localparam logic [DWIDTH-1:0]        MAX_POS  = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
    // Tanh breakpoints F/4, F/2, 3F/4 and final-segment offset 11F/16, F = 2^(DWIDTH-1)
    localparam logic [DWIDTH-1:0] BP1 = DWIDTH'(1) << (DWIDTH - 3);
    localparam logic [DWIDTH-1:0] BP2 = DWIDTH'(1) << (DWIDTH - 2);
    localparam logic [DWIDTH-1:0] BP3 = BP1 + BP2;
    localparam logic [DWIDTH-1:0] OFF = DWIDTH'(11) << (DWIDTH - 5);

    localparam logic [CW-1:0] ROW_TARGET = CW'(ROWS_PER_DONE);

    logic [LANES-2:0] skew;
    logic [LANES-1:0] lane_go;

    assign lane_go = {skew, in_data_available};

    always_ff @(posedge clk) begin
        if (reset) begin
            skew <= '0;
        end else begin
            skew <= lane_go[LANES-2:0];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic                     cap_v;
        logic signed [DWIDTH-1:0] cap_x;
        logic                     cap_m;
        logic [1:0]               cap_mode;
        logic [2:0]               cap_shift;
        logic [DWIDTH-1:0]        cap_mag;

        logic                     s1_v;
        logic signed [DWIDTH-1:0] s1_x;
        logic                     s1_m;
        logic [1:0]               s1_mode;
        logic [2:0]               s1_shift;
        logic [DWIDTH-1:0]        s1_mag;
        logic                     s1_sign;

        logic [DWIDTH-1:0]        p;
        logic [DWIDTH:0]          p_wide;
        logic signed [DWIDTH-1:0] res;

        logic                     out_v;
        logic [DWIDTH-1:0]        out_q;

        // Lane inputs and controls are captured on the lane's own skewed valid
        always_ff @(posedge clk) begin
            if (reset) begin
                cap_v     <= 1'b0;
                cap_x     <= '0;
                cap_m     <= 1'b0;
                cap_mode  <= MODE_BYPASS;
                cap_shift <= '0;
            end else begin
                cap_v <= lane_go[g];
                if (lane_go[g]) begin
                    cap_x     <= inp_data[g*DWIDTH +: DWIDTH];
                    cap_m     <= validity_mask[g];
                    cap_mode  <= enable_activation ? activation_type : MODE_BYPASS;
                    cap_shift <= leak_shift;
                end
            end
        end

        // Most-negative input saturates to F-1 so the magnitude fits DWIDTH-1 bits
        always_comb begin
            cap_mag = $unsigned(cap_x);
            if (cap_x[DWIDTH-1]) begin
                cap_mag = (cap_x == MOST_NEG) ? MAX_POS : $unsigned(-cap_x);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_v     <= 1'b0;
                s1_x     <= '0;
                s1_m     <= 1'b0;
                s1_mode  <= MODE_BYPASS;
                s1_shift <= '0;
                s1_mag   <= '0;
                s1_sign  <= 1'b0;
            end else begin
                s1_v <= cap_v;
                if (cap_v) begin
                    s1_x     <= cap_x;
                    s1_m     <= cap_m;
                    s1_mode  <= cap_mode;
                    s1_shift <= cap_shift;
                    s1_mag   <= cap_mag;
                    s1_sign  <= cap_x[DWIDTH-1];
                end
            end
        end

        always_comb begin
            p      = '0;
            p_wide = '0;
            if (s1_mag < BP1) begin
                p = s1_mag << 1;
            end else if (s1_mag < BP2) begin
                p = s1_mag + BP1;
            end else if (s1_mag < BP3) begin
                p = (s1_mag >> 1) + BP2;
            end else begin
                p_wide = {1'b0, s1_mag >> 2} + {1'b0, OFF};
                p      = (p_wide > {1'b0, MAX_POS}) ? MAX_POS : p_wide[DWIDTH-1:0];
            end
        end

        always_comb begin
            res = s1_x;
            case (s1_mode)
                MODE_RELU:  res = s1_x[DWIDTH-1] ? '0 : s1_x;
                MODE_LEAKY: res = s1_x[DWIDTH-1] ? (s1_x >>> s1_shift) : s1_x;
                MODE_TANH:  res = s1_sign ? -$signed(p) : $signed(p);
                default:    res = s1_x;
            endcase
            if (!s1_m) begin
                res = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                out_v <= 1'b0;
                out_q <= '0;
            end else begin
                out_v <= s1_v;
                if (s1_v) begin
                    out_q <= $unsigned(res);
                end
            end
        end

        assign out_data[g*DWIDTH +: DWIDTH] = out_q;
        assign out_lane_valid[g]            = out_v;
    end

    assign out_data_available = out_lane_valid[LANES-1];

    logic [CW-1:0] row_count;

    // Clear has priority over a coinciding completed row
    always_ff @(posedge clk) begin
        if (reset || done_clear) begin
            row_count       <= '0;
            done_activation <= 1'b0;
        end else if (out_data_available) begin
            if (row_count != ROW_TARGET) begin
                row_count <= row_count + CW'(1);
            end
            if (row_count >= ROW_TARGET - CW'(1)) begin
                done_activation <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_activation_pwl_array.sv
// tb/tb_activation_pwl_array.sv - scoreboard bench for activation_pwl_array
module tb_activation_pwl_array;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  val;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_activation;
    logic [1:0]  activation_type;
    logic [2:0]  leak_shift;
    logic        in_data_available;
    logic [63:0] inp_data;
    logic [7:0]  validity_mask;
    logic        done_clear;
    logic [63:0] out_data;
    logic [7:0]  out_lane_valid;
    logic        out_data_available;
    logic        done_activation;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_t0 = 0;

    ev_t         exp_q [8][$];
    ev_t         obs_q [8][$];
    int          oda_q [$];
    logic [63:0] rows_x [$];
    logic [63:0] rows_e [$];
    logic [7:0]  rows_m [$];

    activation_pwl_array #(.DWIDTH(8), .LANES(8), .ROWS_PER_DONE(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable_activation  (enable_activation),
        .activation_type    (activation_type),
        .leak_shift         (leak_shift),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .done_clear         (done_clear),
        .out_data           (out_data),
        .out_lane_valid     (out_lane_valid),
        .out_data_available (out_data_available),
        .done_activation    (done_activation)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t ev;
        for (int i = 0; i < 8; i++) begin
            if (out_lane_valid[i]) begin
                ev.cyc = cyc;
                ev.val = out_data[i*8 +: 8];
                obs_q[i].push_back(ev);
            end
        end
        if (out_data_available) oda_q.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic stream_rows(input int n);
        logic [63:0] d;
        logic [7:0]  m;
        logic [63:0] rx;
        logic [63:0] re;
        ev_t         ev;
        int          r;
        @(posedge clk); #1;
        last_t0 = cyc + 1;
        for (int k = 0; k < n + 7; k++) begin
            d = '0;
            m = '0;
            for (int i = 0; i < 8; i++) begin
                r = k - i;
                if (r >= 0 && r < n) begin
                    rx = rows_x[r];
                    re = rows_e[r];
                    d[i*8 +: 8] = rx[i*8 +: 8];
                    m[i] = rows_m[r][i];
                    ev.cyc = last_t0 + k + 2;
                    ev.val = rows_m[r][i] ? re[i*8 +: 8] : 8'h00;
                    exp_q[i].push_back(ev);
                end
            end
            in_data_available = (k < n);
            inp_data = d;
            validity_mask = m;
            @(posedge clk); #1;
        end
        in_data_available = 1'b0;
        inp_data = '0;
        validity_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        rows_x.delete();
        rows_e.delete();
        rows_m.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable_activation = 1'b0;
        activation_type = 2'b00;
        leak_shift = 3'd0;
        in_data_available = 1'b0;
        inp_data = '0;
        validity_mask = '0;
        done_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_out_data: actual %h required 0", out_data);
        end
        checks++;
        if (out_lane_valid !== 8'h00 || out_data_available !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: actual %b/%b required 0/0", out_lane_valid, out_data_available);
        end
        checks++;
        if (done_activation !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: actual %b required 0", done_activation);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int l = 0; l < 8; l++) obs_q[l].delete();
        oda_q.delete();
    endtask

    task automatic test_bypass();
        ev_t e;
        ev_t o;
        enable_activation = 1'b0;
        activation_type = 2'b00;
        oda_q.delete();
        rows_x.push_back({8'd3, 8'd2, 8'd1, 8'd0, 8'hFF, 8'hFE, 8'hFD, 8'hFC});
        rows_e.push_back({8'd3, 8'd2, 8'd1, 8'd0, 8'hFF, 8'hFE, 8'hFD, 8'hFC});
        rows_m.push_back(8'hFF);
        stream_rows(1);
        checks++;
        if (oda_q.size() != 1 || oda_q[0] != last_t0 + 9) begin
            failures++;
            $display("FAIL bypass_oda: actual n=%0d first=%0d required n=1 at %0d",
                     oda_q.size(), (oda_q.size() > 0) ? oda_q[0] : -1, last_t0 + 9);
        end
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL bypass lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL bypass lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL bypass lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    task automatic test_relu();
        ev_t e;
        ev_t o;
        enable_activation = 1'b1;
        activation_type = 2'b00;
        rows_x.push_back({8'hCE, 8'h7F, 8'hF9, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h80});
        rows_e.push_back({8'h00, 8'h7F, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00});
        rows_m.push_back(8'hFF);
        rows_x.push_back({8'hCE, 8'h7F, 8'hF9, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h80});
        rows_e.push_back({8'h00, 8'h7F, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00});
        rows_m.push_back(8'b1111_0000);
        stream_rows(2);
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL relu lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL relu lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL relu lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    task automatic test_leaky();
        ev_t e;
        ev_t o;
        enable_activation = 1'b1;
        activation_type = 2'b10;
        leak_shift = 3'd2;
        rows_x.push_back({8'h00, 8'hFE, 8'h64, 8'hC0, 8'h0C, 8'hFF, 8'hFB, 8'h80});
        rows_e.push_back({8'h00, 8'hFF, 8'h64, 8'hF0, 8'h0C, 8'hFF, 8'hFE, 8'hE0});
        rows_m.push_back(8'hFF);
        stream_rows(1);
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL leaky lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL leaky lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL leaky lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    task automatic test_tanh();
        ev_t e;
        ev_t o;
        enable_activation = 1'b1;
        activation_type = 2'b01;
        rows_x.push_back({8'h60, 8'h50, 8'h40, 8'h32, 8'h20, 8'h1F, 8'h0A, 8'h00});
        rows_e.push_back({8'h70, 8'h68, 8'h60, 8'h52, 8'h40, 8'h3E, 8'h14, 8'h00});
        rows_m.push_back(8'hFF);
        rows_x.push_back({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hD8, 8'h80, 8'h7F});
        rows_e.push_back({8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h89, 8'h77});
        rows_m.push_back(8'hFF);
        stream_rows(2);
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL tanh lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL tanh lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL tanh lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    task automatic test_back_to_back_done();
        ev_t         e;
        ev_t         o;
        logic [63:0] v;
        enable_activation = 1'b1;
        activation_type = 2'b11;
        @(posedge clk); #1;
        done_clear = 1'b1;
        @(posedge clk); #1;
        done_clear = 1'b0;
        oda_q.delete();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(r * 16 + i - 40);
            rows_x.push_back(v);
            rows_e.push_back(v);
            rows_m.push_back(8'hFF);
        end
        fork
            stream_rows(6);
            begin
                @(posedge clk); #2;
                for (int w = 0; w < 100 && cyc < last_t0 + 12; w++) @(negedge clk);
                checks++;
                if (done_activation !== 1'b0 || dut.row_count !== 3'd3) begin
                    failures++;
                    $display("FAIL done_before4: actual done=%b cnt=%0d required done=0 cnt=3", done_activation, dut.row_count);
                end
                @(posedge clk); #1;
                checks++;
                if (done_activation !== 1'b1 || dut.row_count !== 3'd4 || out_data_available !== 1'b1) begin
                    failures++;
                    $display("FAIL done_after4: actual done=%b cnt=%0d oda=%b required 1/4/1", done_activation, dut.row_count, out_data_available);
                end
                done_clear = 1'b1;
                @(posedge clk); #1;
                done_clear = 1'b0;
                checks++;
                if (done_activation !== 1'b0 || dut.row_count !== 3'd0 || out_data_available !== 1'b1) begin
                    failures++;
                    $display("FAIL done_clear_wins: actual done=%b cnt=%0d oda=%b required 0/0/1", done_activation, dut.row_count, out_data_available);
                end
                @(posedge clk); #1;
                checks++;
                if (done_activation !== 1'b0 || dut.row_count !== 3'd1) begin
                    failures++;
                    $display("FAIL row6_counted: actual done=%b cnt=%0d required done=0 cnt=1", done_activation, dut.row_count);
                end
            end
        join
        checks++;
        if (oda_q.size() != 6) begin
            failures++;
            $display("FAIL oda_count: actual %0d required 6", oda_q.size());
        end
        for (int r = 0; r < 6 && r < oda_q.size(); r++) begin
            checks++;
            if (oda_q[r] != last_t0 + 9 + r) begin
                failures++;
                $display("FAIL oda_row%0d: actual %0d required %0d", r, oda_q[r], last_t0 + 9 + r);
            end
        end
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL stream lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL stream lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL stream lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    task automatic test_reset_midstream();
        ev_t e;
        ev_t o;
        enable_activation = 1'b1;
        activation_type = 2'b00;
        @(posedge clk); #1;
        inp_data = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h08};
        validity_mask = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            in_data_available = (k == 0);
            reset = (k == 3);
            @(posedge clk); #1;
        end
        checks++;
        if (out_lane_valid !== 8'h00 || out_data_available !== 1'b0 || out_data !== 64'h0) begin
            failures++;
            $display("FAIL midreset_outputs: actual v=%b oda=%b d=%h required all 0", out_lane_valid, out_data_available, out_data);
        end
        checks++;
        if (done_activation !== 1'b0 || dut.row_count !== 3'd0) begin
            failures++;
            $display("FAIL midreset_counter: actual done=%b cnt=%0d required 0/0", done_activation, dut.row_count);
        end
        reset = 1'b0;
        in_data_available = 1'b0;
        inp_data = '0;
        validity_mask = '0;
        for (int l = 0; l < 8; l++) obs_q[l].delete();
        oda_q.delete();
        repeat (12) @(posedge clk);
        #1;
        for (int l = 0; l < 8; l++) begin
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL stale_lane%0d: actual %0d valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
        rows_x.push_back({8'hCE, 8'h7F, 8'hF9, 8'h05, 8'h01, 8'h00, 8'hFF, 8'h80});
        rows_e.push_back({8'h00, 8'h7F, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00});
        rows_m.push_back(8'hFF);
        stream_rows(1);
        for (int l = 0; l < 8; l++) begin
            while (exp_q[l].size() > 0) begin
                e = exp_q[l].pop_front();
                checks++;
                if (obs_q[l].size() == 0) begin
                    failures++;
                    $display("FAIL postreset lane%0d: actual none required %h@%0d", l, e.val, e.cyc);
                end else begin
                    o = obs_q[l].pop_front();
                    if (o.val !== e.val || o.cyc !== e.cyc) begin
                        failures++;
                        $display("FAIL postreset lane%0d: actual %h@%0d required %h@%0d", l, o.val, o.cyc, e.val, e.cyc);
                    end
                end
            end
            checks++;
            if (obs_q[l].size() != 0) begin
                failures++;
                $display("FAIL postreset lane%0d extra: actual %0d extra valids required 0", l, obs_q[l].size());
                obs_q[l].delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_relu();
        test_leaky();
        test_tanh();
        test_back_to_back_done();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
